// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the SRAM port initiator.
package mem_port_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = MEM_DATA_WIDTH / 8;

  // One response entry as it sits in the response FIFO.
  typedef struct packed {
    logic                      write;
    logic [MEM_DATA_WIDTH-1:0] rdata;
  } mem_rsp_t;

  // Credit sum needs one bit more than the occupancy counter so that
  // count + inflight cannot wrap before the compare.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/mem_port_master_resp_fifo.sv
// Generic synchronous FIFO; output is presented from the head entry.
module resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only and is never cleared.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= din;
  end

  assign dout  = store[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  pop_on_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/mem_port_master.sv
// Valid/ready request channel to single-port SRAM cycles, with in-order
// responses returned through a credit-protected response FIFO.
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_write_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int CRD_W  = credit_width(RESP_DEPTH);
  localparam int FIFO_W = DATA_WIDTH + 1;

  logic                  accept;
  logic                  pop;
  logic                  vld_p1;
  logic                  we_p1;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic [CRD_W-1:0]      credit;
  logic [DATA_WIDTH-1:0] cap_rdata;
  logic [FIFO_W-1:0]     push_data;
  logic [FIFO_W-1:0]     head;

  // ---- stage p0: accept and drive the SRAM port in the same cycle
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign credit      = CRD_W'(count) + CRD_W'(vld_p1) - CRD_W'(pop);
  assign req_ready_o = !rst & (credit < CRD_W'(RESP_DEPTH));
  assign accept      = req_valid_i & req_ready_o;

  assign mem_en_o    = accept;
  assign mem_we_o    = accept ? req_we_i    : 1'b0;
  assign mem_addr_o  = accept ? req_addr_i  : '0;
  assign mem_be_o    = accept ? req_be_i    : '0;
  assign mem_wdata_o = accept ? req_wdata_i : '0;

  // Inflight marker: one cycle behind accept, dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  // Direction of the inflight access travels alongside the marker.
  always_ff @(posedge clk) begin
    we_p1 <= req_we_i;
  end

  // ---- stage p1: SRAM read data is valid; capture into the FIFO
  assign cap_rdata = we_p1 ? '0 : mem_rdata_i;
  assign push_data = {we_p1, cap_rdata};

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (FIFO_W)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // ---- stage p2: response presented from the FIFO head
  assign rsp_valid_o = !empty & !rst;
  assign rsp_write_o = rsp_valid_o & head[FIFO_W-1];
  assign rsp_rdata_o = rsp_valid_o ? head[DATA_WIDTH-1:0] : '0;

  push_overflow: assert property (@(posedge clk) disable iff (rst) !(vld_p1 && full && !pop));

endmodule

// File: tb/tb_mem_port_master.sv
// Directed and random checks for mem_port_master against a small SRAM model.
module tb_mem_port_master;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [BW-1:0] req_be;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_write;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_be_i    (req_be),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_write_o (rsp_write),
    .mem_en_o    (mem_en),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // SRAM model: 64 words, byte-enabled writes, read data one cycle later.
  logic [DW-1:0] sram [64];
  logic          pl_en  = 1'b0;
  logic          pl_clr = 1'b0;
  logic [5:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_clr) for (int i = 0; i < 64; i++) sram[i] = '0;
    if (pl_en) sram[pl_addr] = pl_data;
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) sram[mem_addr[5:0]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[5:0]];
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    next_cycle();
    pl_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_addr = 15'h0007; req_we = 1'b1;
    req_be = '1; req_wdata = '1; rsp_ready = 1'b1; pl_clr = 1'b1;
    next_cycle();
    pl_clr = 1'b0;
    @(negedge clk);
    tests++;
    if ({req_ready, mem_en, mem_we} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl got ready/en/we=%b required 000", {req_ready, mem_en, mem_we});
    end
    tests++;
    if ({mem_addr, mem_be, mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_memdata got addr=%h be=%h wdata=%h required 0", mem_addr, mem_be, mem_wdata);
    end
    tests++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== '0) begin
      fails++; $display("FAIL reset_rsp got valid=%b write=%b rdata=%h required 0", rsp_valid, rsp_write, rsp_rdata);
    end
    next_cycle();
    rst = 1'b0; req_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read;
    preload(6'h10, 32'hDEADBEEF);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 15'h0010; req_we = 1'b0; req_be = '1; req_wdata = '0;
    @(negedge clk);
    tests++;
    if ({req_ready, mem_en, mem_we, mem_addr} !== {3'b110, 15'h0010}) begin
      fails++; $display("FAIL read_issue got ready=%b en=%b we=%b addr=%h required 1 1 0 0010", req_ready, mem_en, mem_we, mem_addr);
    end
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL read_early got rsp_valid=%b at T+1 required 0", rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      fails++; $display("FAIL read_rsp got valid=%b write=%b rdata=%h required 1 0 deadbeef", rsp_valid, rsp_write, rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_write;
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h0004;
    req_be = 4'b0011; req_wdata = 32'h12345678;
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== {2'b11, 15'h0004, 4'h3, 32'h12345678}) begin
      fails++; $display("FAIL write_issue got en=%b we=%b addr=%h be=%h wdata=%h required 1 1 0004 3 12345678", mem_en, mem_we, mem_addr, mem_be, mem_wdata);
    end
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_en, mem_be, mem_wdata, rsp_valid} !== '0) begin
      fails++; $display("FAIL write_idle got en=%b be=%h wdata=%h rsp_valid=%b required all 0", mem_en, mem_be, mem_wdata, rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {2'b11, 32'h0}) begin
      fails++; $display("FAIL write_rsp got valid=%b write=%b rdata=%h required 1 1 0", rsp_valid, rsp_write, rsp_rdata);
    end
    next_cycle();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0004;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {2'b10, 32'h00005678}) begin
      fails++; $display("FAIL write_readback got valid=%b write=%b rdata=%h required 1 0 00005678", rsp_valid, rsp_write, rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) preload(6'(i), 32'hA0000000 + 32'(i));
    rsp_ready = 1'b1; req_we = 1'b0; req_be = '1;
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 8);
      req_addr  = AW'(c);
      @(negedge clk);
      if (c < 8) begin
        tests++;
        if (req_ready !== 1'b1) begin
          fails++; $display("FAIL b2b_ready cycle %0d got %b required 1", c, req_ready);
        end
      end
      if (c >= 2 && c < 10) begin
        tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA0000000 + 32'(c - 2)}) begin
          fails++; $display("FAIL b2b_rsp cycle %0d got valid=%b rdata=%h required 1 %h", c, rsp_valid, rsp_rdata, 32'hA0000000 + 32'(c - 2));
        end
      end else begin
        tests++;
        if (rsp_valid !== 1'b0) begin
          fails++; $display("FAIL b2b_idle cycle %0d got rsp_valid=%b required 0", c, rsp_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure;
    int acc;
    logic [DW-1:0] expd [3];
    expd[0] = 32'hB0000000; expd[1] = 32'hB0000001; expd[2] = 32'hB0000002;
    for (int k = 0; k < 3; k++) preload(6'h20 + 6'(k), expd[k]);
    acc = 0;
    rsp_ready = 1'b0; req_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      req_addr  = 15'h0020 + AW'(acc);
      @(negedge clk);
      if (req_ready) acc++;
      if (c >= 2) begin
        tests++;
        if ({req_ready, rsp_valid, rsp_rdata} !== {2'b01, expd[0]}) begin
          fails++; $display("FAIL bp_hold cycle %0d got ready=%b valid=%b rdata=%h required 0 1 %h", c, req_ready, rsp_valid, rsp_rdata, expd[0]);
        end
      end
      next_cycle();
    end
    tests++;
    if (acc !== 2) begin
      fails++; $display("FAIL bp_accepts got %0d required 2", acc);
    end
    for (int d = 0; d < 4; d++) begin
      rsp_ready = 1'b1;
      req_valid = (d == 0);
      req_addr  = 15'h0020 + AW'(acc);
      @(negedge clk);
      if (d == 0) begin
        tests++;
        if (req_ready !== 1'b1) begin
          fails++; $display("FAIL bp_resume got ready=%b required 1", req_ready);
        end
      end
      if (d < 3) begin
        tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, expd[d]}) begin
          fails++; $display("FAIL bp_drain step %0d got valid=%b rdata=%h required 1 %h", d, rsp_valid, rsp_rdata, expd[d]);
        end
      end else begin
        tests++;
        if (rsp_valid !== 1'b0) begin
          fails++; $display("FAIL bp_empty got rsp_valid=%b required 0", rsp_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid;
    preload(6'h30, 32'hCAFE0000);
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0030;
    @(negedge clk);
    tests++;
    if (mem_en !== 1'b1) begin
      fails++; $display("FAIL rmid_issue got en=%b required 1", mem_en);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, mem_en} !== 3'b000) begin
      fails++; $display("FAIL rmid_during got ready/valid/en=%b required 000", {req_ready, rsp_valid, mem_en});
    end
    next_cycle();
    rst = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL rmid_ghost cycle %0d got rsp_valid=%b required 0", c, rsp_valid);
      end
      next_cycle();
    end
    req_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_after_ready got %b required 1", req_ready);
    end
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {2'b10, 32'hCAFE0000}) begin
      fails++; $display("FAIL rmid_after_rsp got valid=%b write=%b rdata=%h required 1 0 cafe0000", rsp_valid, rsp_write, rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_random;
    logic [DW-1:0] ref_mem [16];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   e;
    logic [DW:0]   hold_val;
    logic [DW-1:0] mask;
    logic          hold_pend;
    int issued, got, cyc;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h50000000 + 32'(i);
      preload(6'(i), ref_mem[i]);
    end
    issued = 0; got = 0; cyc = 0; hold_pend = 1'b0; hold_val = '0;
    while ((issued < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      cyc++;
      req_valid = (issued < 1000) && ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 15));
      req_be    = BW'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (hold_pend) begin
        tests++;
        if ({rsp_valid, rsp_write, rsp_rdata} !== {1'b1, hold_val}) begin
          fails++; $display("FAIL rnd_hold cycle %0d got valid=%b %h required 1 %h", cyc, rsp_valid, {rsp_write, rsp_rdata}, hold_val);
        end
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        got++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rnd_extra cycle %0d got unexpected response %h required none", cyc, {rsp_write, rsp_rdata});
        end else begin
          e = exp_q.pop_front();
          if ({rsp_write, rsp_rdata} !== e) begin
            fails++; $display("FAIL rnd_data rsp %0d got %h required %h", got, {rsp_write, rsp_rdata}, e);
          end
        end
      end
      hold_pend = rsp_valid && !rsp_ready;
      hold_val  = {rsp_write, rsp_rdata};
      if (req_valid && req_ready) begin
        issued++;
        if (req_we) begin
          for (int b = 0; b < BW; b++) mask[8*b +: 8] = {8{req_be[b]}};
          ref_mem[req_addr[3:0]] = (ref_mem[req_addr[3:0]] & ~mask) | (req_wdata & mask);
          exp_q.push_back({1'b1, 32'h0});
        end else begin
          exp_q.push_back({1'b0, ref_mem[req_addr[3:0]]});
        end
      end
      next_cycle();
    end
    req_valid = 1'b0;
    tests++;
    if (issued != 1000 || got != 1000) begin
      fails++; $display("FAIL rnd_count got issued=%0d responses=%0d required 1000 1000", issued, got);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator for the single-port SRAM request interface (en/addr/we/be/wdata/rdata) used by the instruction and data RAM wrappers.
- Converts a valid/ready request channel from an upstream bus adapter into SRAM port cycles.
- Captures read data one cycle after issue and returns every transaction as a response on a valid/ready channel.
- Sits in the low power domain, in front of the memory-domain crossing.

Parameters:
- ADDR_WIDTH, 15: word address width on both request and memory sides.
- DATA_WIDTH, 32: data width. BE width is DATA_WIDTH/8.
- RESP_DEPTH, 2: response FIFO entries. Must be >= 2. Power of two not required.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_addr_i  in  ADDR_WIDTH  word address
- req_we_i  in  1  1 = write, 0 = read
- req_be_i  in  DATA_WIDTH/8  byte enables
- req_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for write responses
- rsp_write_o  out  1  response belongs to a write
- mem_en_o  out  1  SRAM enable
- mem_addr_o  out  ADDR_WIDTH  SRAM address
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; count=0; inflight flag cleared.
  - rsp_valid_o=0, rsp_write_o=0, rsp_rdata_o=0.
  - req_ready_o=0 while rst is high.
  - mem_en_o=0 while rst is high; all mem_* data outputs 0.
- Accept and issue:
  - accept = req_valid_i & req_ready_o.
  - mem_en_o = accept, combinational same cycle (SRAM samples at the next edge).
  - mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o follow the request when accept=1. They are forced to 0 when accept=0.
- Inflight register: set on accept, capturing the we bit. Cleared otherwise.
- Capture (cycle after accept, inflight=1): push {write=we, rdata = we ? 0 : mem_rdata_i} into the FIFO.
- Latency: request accepted in cycle T -> rsp_valid_o=1 from cycle T+2.
- Credit rule:
  - pop = rsp_valid_o & rsp_ready_i.
  - req_ready_o = !rst & ((count + inflight - pop) < RESP_DEPTH).
  - This guarantees the capture push never overflows.
  - With RESP_DEPTH=2 and rsp_ready_i held 1, one request per cycle is sustained.
- FIFO:
  - Output presented from the head register.
  - Simultaneous push and pop in one cycle keeps count unchanged; order is preserved.
  - Pop on empty is impossible (rsp_valid_o=0).
  - Push with count==RESP_DEPTH and no pop is an assertion failure and unreachable by construction.
  - Pointers wrap modulo RESP_DEPTH.
- Response hold: rsp_* are stable while rsp_valid_o & !rsp_ready_i.
- Ordering: responses are returned strictly in acceptance order, reads and writes interleaved.
- Reset mid-operation:
  - Any inflight read is discarded.
  - mem_rdata_i in the cycle after reset is ignored.
  - No response is produced for requests accepted before reset.
- Counter widths: count is $clog2(RESP_DEPTH+1) bits. The credit sum is computed one bit wider to avoid wrap.

Decomposition:
- Package mem_port_pkg holds:
  - typedef mem_rsp_t (packed struct {write, rdata}).
  - localparam BE_WIDTH = DATA_WIDTH/8.
  - function for credit width.
- One sub-module: resp_fifo (generic synchronous FIFO with parameters DEPTH and WIDTH, push/pop/count/full/empty, synchronous active-high reset). Credit logic and inflight stay in mem_port_master.

Test Plan:
- Single read: rsp_ready_i=1; read addr 0x0010 at T; SRAM model returns 0xDEADBEEF at T+1.
  -> mem_en_o=1 and mem_we_o=0 at T; rsp_valid_o=1, rsp_rdata_o=0xDEADBEEF, rsp_write_o=0 at T+2.
- Write: addr 0x0004, be=4'b0011, wdata=0x12345678.
  -> mem_be_o=0x3 and mem_wdata_o=0x12345678 at T; response with rsp_write_o=1 and rsp_rdata_o=0 at T+2; a later read of 0x0004 returns 0x00005678 (model preloaded to 0).
- Back-to-back: 8 reads of addrs 0..7 with req_valid_i and rsp_ready_i held 1.
  -> req_ready_o=1 every cycle; 8 responses on consecutive cycles in order.
- Backpressure: rsp_ready_i=0, req_valid_i held 1.
  -> exactly 2 accepts, then req_ready_o=0; head response stable. Raise rsp_ready_i.
  -> drain in order; accepts resume the same cycle as the first pop.
- Reset mid-operation: assert rst the cycle after a read accept.
  -> no response emerges; rsp_valid_o=0 and req_ready_o=0 during reset; the next request after reset works normally.
- Mixed random: 1000 random reads/writes with random rsp_ready_i, against a scoreboard memory model.
  -> all data matches; no FIFO overflow assertion fires; order is preserved.
